// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types.
//   word_t        - 32-bit datapath word, also used for the debug counters
//   regbits_t     - 5-bit register specifier
//   pctrl_state_t - sequencing states of pipeline_ctrl
//   sat_inc()     - increment that sticks at the all-ones value
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    RUN,
    DWAIT,
    HALTED
  } pctrl_state_t;

  localparam word_t CNT_MAX = '1;

  // Debug counters must never wrap back to zero, so they stop at all-ones.
  function automatic word_t sat_inc(input word_t value);
    return (value == CNT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use detector.
//   idex_memread   in  ID/EX holds a load
//   idex_rt        in  destination register of that load
//   ifid_rs/rt     in  source registers of the instruction in ID
//   load_use       out the ID instruction needs the load result next cycle
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_memread,
  input  regbits_t idex_rt,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     load_use
);

  // Register zero is hardwired, so a load into it never creates a dependency.
  always_comb begin
    load_use = idex_memread && (idex_rt != '0) &&
               ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the five-stage pipeline.
//   CLK, RST                        clock, synchronous active-high reset
//   ihit, dhit                      instruction / data memory completion
//   ifid_rs, ifid_rt                sources of the instruction in ID
//   idex_memread, idex_rt           load in ID/EX and its destination
//   exmem_memread, exmem_memwrite   memory access in MEM
//   branch_taken                    resolved taken branch or jump
//   halt_id, halt_wb                halt decoded in ID / reached MEM/WB
//   pc_wen, *_wen                   PC and pipeline register write enables
//   ifid/idex/exmem_flush           load a bubble on the next edge
//   halt                            CPU halted (sticky until reset)
//   stall_cnt, flush_cnt            saturating debug counters
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     ihit,
  input  logic     dhit,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  input  logic     idex_memread,
  input  regbits_t idex_rt,
  input  logic     exmem_memread,
  input  logic     exmem_memwrite,
  input  logic     branch_taken,
  input  logic     halt_id,
  input  logic     halt_wb,
  output logic     pc_wen,
  output logic     ifid_wen,
  output logic     idex_wen,
  output logic     exmem_wen,
  output logic     memwb_wen,
  output logic     ifid_flush,
  output logic     idex_flush,
  output logic     exmem_flush,
  output logic     halt,
  output word_t    stall_cnt,
  output word_t    flush_cnt
);

  pctrl_state_t state;
  logic         draining;
  logic         load_use;
  logic         mem_wait;
  logic         squash;

  hazard_detect u_hazard (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .load_use     (load_use)
  );

  assign mem_wait = (exmem_memread || exmem_memwrite) && !dhit;

  // Priority mux: each branch overrides everything below it. The branch
  // squash also discards any load-use pair, so no stall cycle is spent.
  always_comb begin
    pc_wen      = 1'b0;
    ifid_wen    = 1'b0;
    idex_wen    = 1'b0;
    exmem_wen   = 1'b0;
    memwb_wen   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    squash      = 1'b0;
    if (RST || state == HALTED) begin
      // everything frozen
    end else if (mem_wait) begin
      // full freeze until the data memory answers
    end else if (branch_taken) begin
      squash      = 1'b1;
      pc_wen      = ihit;
      ifid_wen    = 1'b1;
      idex_wen    = 1'b1;
      exmem_wen   = 1'b1;
      memwb_wen   = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      idex_wen    = 1'b1;
      exmem_wen   = 1'b1;
      memwb_wen   = 1'b1;
      idex_flush  = 1'b1;
    end else if (!ihit || draining) begin
      ifid_wen    = 1'b1;
      idex_wen    = 1'b1;
      exmem_wen   = 1'b1;
      memwb_wen   = 1'b1;
      ifid_flush  = 1'b1;
    end else begin
      pc_wen      = 1'b1;
      ifid_wen    = 1'b1;
      idex_wen    = 1'b1;
      exmem_wen   = 1'b1;
      memwb_wen   = 1'b1;
    end
    // Once a halt is in flight nothing new may be fetched.
    if (draining) begin
      pc_wen = 1'b0;
    end
  end

  assign halt = (state == HALTED) && !RST;

  // Sequencing state, drain flag and counters. Counters are frozen in
  // HALTED simply by not updating them there.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      draining  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != HALTED) begin
        if (!pc_wen) begin
          stall_cnt <= sat_inc(stall_cnt);
        end
        if (squash) begin
          flush_cnt <= sat_inc(flush_cnt);
        end
        if (halt_id) begin
          draining <= 1'b1;
        end
      end
      case (state)
        RUN: begin
          if (halt_wb) begin
            state <= HALTED;
          end else if (mem_wait) begin
            state <= DWAIT;
          end
        end
        DWAIT: begin
          if (halt_wb) begin
            state <= HALTED;
          end else if (dhit) begin
            state <= RUN;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios followed by randomized traffic,
// all checked against a rule-level reference model of the controller.
module tb_pipeline_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit;
  logic [4:0]  ifid_rs, ifid_rt, idex_rt;
  logic        idex_memread, exmem_memread, exmem_memwrite;
  logic        branch_taken, halt_id, halt_wb;
  logic        pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
  logic        ifid_flush, idex_flush, exmem_flush, halt;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int passes = 0;

  // Reference model state: only what is visible at the ports matters.
  bit          m_halted;
  bit          m_draining;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  typedef struct packed {
    logic       rst;
    logic       ihit;
    logic       dhit;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       idex_memread;
    logic [4:0] idex_rt;
    logic       exr;
    logic       exw;
    logic       br;
    logic       hid;
    logic       hwb;
  } stim_t;

  pipeline_ctrl dut (
    .CLK            (CLK),
    .RST            (RST),
    .ihit           (ihit),
    .dhit           (dhit),
    .ifid_rs        (ifid_rs),
    .ifid_rt        (ifid_rt),
    .idex_memread   (idex_memread),
    .idex_rt        (idex_rt),
    .exmem_memread  (exmem_memread),
    .exmem_memwrite (exmem_memwrite),
    .branch_taken   (branch_taken),
    .halt_id        (halt_id),
    .halt_wb        (halt_wb),
    .pc_wen         (pc_wen),
    .ifid_wen       (ifid_wen),
    .idex_wen       (idex_wen),
    .exmem_wen      (exmem_wen),
    .memwb_wen      (memwb_wen),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .halt           (halt),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 CLK = ~CLK;

  // Counts every comparison and reports any disagreement.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.ihit = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] sat_next(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Expected {pc, ifid_wen, idex_wen, exmem_wen, memwb_wen,
  //           ifid_flush, idex_flush, exmem_flush} from the priority rules.
  function automatic logic [7:0] model_ctl(input stim_t s, output bit sq);
    bit         busy;
    bit         hazard;
    logic [7:0] r;
    busy   = (s.exr || s.exw) && !s.dhit;
    hazard = s.idex_memread && (s.idex_rt != 5'd0) &&
             ((s.idex_rt == s.rs) || (s.idex_rt == s.rt));
    sq = 1'b0;
    if (s.rst || m_halted)      r = 8'b0000_0000;
    else if (busy)              r = 8'b0000_0000;
    else if (s.br) begin
      sq = 1'b1;
      r  = {s.ihit, 7'b1111_111};
    end
    else if (hazard)            r = 8'b0011_1010;
    else if (!s.ihit || m_draining) r = 8'b0111_1100;
    else                        r = 8'b1111_1000;
    if (m_draining) r[7] = 1'b0;
    return r;
  endfunction

  // Drives one cycle of inputs, checks the outputs against the model and
  // then advances the model across the rising edge.
  task automatic applyStimulus(input stim_t s, input string tag);
    logic [7:0] exp_ctl;
    bit         sq;
    @(negedge CLK);
    RST            = s.rst;
    ihit           = s.ihit;
    dhit           = s.dhit;
    ifid_rs        = s.rs;
    ifid_rt        = s.rt;
    idex_memread   = s.idex_memread;
    idex_rt        = s.idex_rt;
    exmem_memread  = s.exr;
    exmem_memwrite = s.exw;
    branch_taken   = s.br;
    halt_id        = s.hid;
    halt_wb        = s.hwb;
    #1;
    exp_ctl = model_ctl(s, sq);
    checkOutput({tag, ":ctl"},
                {24'd0, pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
                 ifid_flush, idex_flush, exmem_flush}, {24'd0, exp_ctl});
    checkOutput({tag, ":halt"}, {31'd0, halt}, {31'd0, (m_halted && !s.rst)});
    checkOutput({tag, ":stall_cnt"}, stall_cnt, m_stall);
    checkOutput({tag, ":flush_cnt"}, flush_cnt, m_flush);
    if (s.rst) begin
      m_halted   = 1'b0;
      m_draining = 1'b0;
      m_stall    = '0;
      m_flush    = '0;
    end else begin
      if (!m_halted) begin
        if (!exp_ctl[7]) m_stall = sat_next(m_stall);
        if (sq)          m_flush = sat_next(m_flush);
        if (s.hid)       m_draining = 1'b1;
      end
      if (s.hwb) m_halted = 1'b1;
    end
  endtask

  task automatic doReset(input string tag);
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    applyStimulus(s, tag);
  endtask

  initial begin
    stim_t s;

    // Bring the counters out of X before any comparison is made.
    RST = 1'b1; ihit = 1'b1; dhit = 1'b0; ifid_rs = '0; ifid_rt = '0;
    idex_memread = 1'b0; idex_rt = '0; exmem_memread = 1'b0;
    exmem_memwrite = 1'b0; branch_taken = 1'b0; halt_id = 1'b0; halt_wb = 1'b0;
    repeat (2) @(posedge CLK);
    m_halted = 1'b0; m_draining = 1'b0; m_stall = '0; m_flush = '0;

    doReset("reset");
    for (int i = 0; i < 10; i++) applyStimulus(idle(), "idle");
    checkOutput("idle_stall_zero", stall_cnt, 32'd0);

    // Load-use stall, then the same pattern through register zero.
    s = idle(); s.idex_memread = 1'b1; s.idex_rt = 5'd5; s.rs = 5'd5;
    applyStimulus(s, "load_use");
    applyStimulus(idle(), "after_load_use");
    checkOutput("load_use_stall_cnt", stall_cnt, 32'd1);
    s = idle(); s.idex_memread = 1'b1; s.idex_rt = 5'd0; s.rs = 5'd0;
    applyStimulus(s, "load_use_r0");
    applyStimulus(idle(), "after_load_use_r0");
    checkOutput("r0_no_stall", stall_cnt, 32'd1);

    // Three-cycle data memory wait, then the completing cycle.
    s = idle(); s.exr = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(s, "dwait");
    s.dhit = 1'b1;
    applyStimulus(s, "dwait_done");
    checkOutput("dwait_pc_wen", {31'd0, pc_wen}, 32'd1);
    applyStimulus(idle(), "after_dwait");
    checkOutput("dwait_stall_cnt", stall_cnt, 32'd4);

    // Branch wins over a simultaneous load-use hazard.
    s = idle(); s.br = 1'b1; s.idex_memread = 1'b1; s.idex_rt = 5'd7; s.rt = 5'd7;
    applyStimulus(s, "branch_lu");
    applyStimulus(idle(), "after_branch");
    checkOutput("branch_flush_cnt", flush_cnt, 32'd1);
    checkOutput("branch_stall_same", stall_cnt, 32'd4);

    // Branch while the instruction memory is still busy.
    s = idle(); s.br = 1'b1; s.ihit = 1'b0;
    applyStimulus(s, "branch_no_ihit");

    // Reset in the middle of a data wait.
    s = idle(); s.exw = 1'b1;
    applyStimulus(s, "dwait_pre_rst");
    applyStimulus(s, "dwait_pre_rst");
    doReset("rst_in_dwait");
    applyStimulus(idle(), "after_rst_dwait");
    checkOutput("rst_dwait_stall", stall_cnt, 32'd0);

    // Halt drain: halt in ID, halt reaches WB three cycles later.
    doReset("reset_halt");
    s = idle(); s.hid = 1'b1;
    applyStimulus(s, "halt_id");
    applyStimulus(idle(), "drain");
    applyStimulus(idle(), "drain");
    s = idle(); s.hwb = 1'b1;
    applyStimulus(s, "halt_wb");
    s = idle(); s.br = 1'b1; s.exr = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(s, "halted");
    checkOutput("halted_flag", {31'd0, halt}, 32'd1);
    checkOutput("halted_stall_frozen", stall_cnt, 32'd3);
    doReset("rst_from_halt");
    applyStimulus(idle(), "after_halt_rst");
    checkOutput("halt_cleared", {31'd0, halt}, 32'd0);

    // Randomized traffic with occasional resets and halts.
    doReset("reset_rand");
    for (int i = 0; i < 400; i++) begin
      s = '0;
      s.rst          = ($urandom_range(0, 49) == 0);
      s.ihit         = ($urandom_range(0, 9) < 8);
      s.dhit         = ($urandom_range(0, 9) < 6);
      s.rs           = 5'($urandom_range(0, 3));
      s.rt           = 5'($urandom_range(0, 3));
      s.idex_memread = ($urandom_range(0, 1) == 1);
      s.idex_rt      = 5'($urandom_range(0, 3));
      s.exr          = ($urandom_range(0, 3) == 0);
      s.exw          = ($urandom_range(0, 5) == 0);
      s.br           = ($urandom_range(0, 6) == 0);
      s.hid          = ($urandom_range(0, 59) == 0);
      s.hwb          = ($urandom_range(0, 89) == 0);
      applyStimulus(s, "random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
